video_capture: RTL and testbench

- Frame grabber sitting on the pixel-clock side of the display pipeline; snoops the RGB444 output stream (r/g/b, de, hsync, vsync, newframe) produced by the video generator.
- On request, decimates one complete frame 2:1 horizontally and vertically, packs two pixels per 32-bit word and writes them sequentially to a capture memory through a valid/ready write port.
- Used for screenshots and as a self-check of the video path. It is the receiving end of the video output interface.

---
 rtl/video_capture.sv | 223 ++++++++++++++++++++++
 tb/tb_video_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// Frame grabber on the pixel clock: decimates one RGB444 frame 2:1 in x and y,
// packs two pixels per 32-bit word and streams them to a capture memory.
module video_capture #(
  parameter int H_ACTIVE   = 704,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        video_r,
  input  logic [3:0]        video_g,
  input  logic [3:0]        video_b,
  input  logic              video_de,
  input  logic              video_hsync,
  input  logic              video_vsync,
  input  logic              video_newframe,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_geom,
  output logic [ADDR_W-1:0] words_written,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PX_W  = $clog2(H_ACTIVE + 2) + 1;
  localparam int LN_W  = $clog2(V_ACTIVE + 1);
  localparam int ENT_W = ADDR_W + 32;

  logic [2:0]        state_q, state_d;
  logic              de_q;
  logic [PX_W-1:0]   px_q, px_d;
  logic [LN_W-1:0]   ln_q, ln_d;
  logic              half_q, half_d;
  logic [11:0]       pack_q, pack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              geom_q, geom_d;
  logic [ADDR_W-1:0] words_q, words_d;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  logic              de_rise, de_fall, last_line, fifo_full;
  logic              push, push_ok, pop;
  logic [PX_W-1:0]   pix_idx;
  logic [11:0]       pixel;
  logic [31:0]       push_word;
  logic              unused_sync;

  assign unused_sync = video_hsync ^ video_vsync;
  assign pixel       = {video_r, video_g, video_b};
  assign de_rise     = video_de & ~de_q;
  assign de_fall     = ~video_de & de_q;
  assign pix_idx     = de_rise ? '0 : px_q;
  assign last_line   = (ln_q == LN_W'(V_ACTIVE - 1));
  assign fifo_full   = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop         = (cnt_q != '0) && (!wr_valid_q || wr_ready);
  assign push_ok     = push && !fifo_full;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    ln_d      = ln_q;
    half_d    = half_q;
    pack_d    = pack_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    geom_d    = geom_q;
    push      = 1'b0;
    push_word = '0;
    words_d   = (wr_valid_q && wr_ready) ? words_q + ADDR_W'(1) : words_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ARMED;
            px_d    = '0;
            ln_d    = '0;
            half_d  = 1'b0;
            pack_d  = '0;
            addr_d  = '0;
            ovf_d   = 1'b0;
            geom_d  = 1'b0;
            words_d = '0;
          end
        end
        ST_ARMED: begin
          if (video_newframe) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // A newframe cycle belongs to the next frame, so nothing is sampled in it.
          if (video_de && !video_newframe) begin
            px_d = (&pix_idx) ? pix_idx : pix_idx + PX_W'(1);
            if (!pix_idx[0] && !ln_q[0]) begin
              if (half_q) begin
                push      = 1'b1;
                push_word = {4'h0, pixel, 4'h0, pack_q};
                half_d    = 1'b0;
              end else begin
                pack_d = pixel;
                half_d = 1'b1;
              end
            end
          end
          if (de_fall) begin
            ln_d = ln_q + LN_W'(1);
            if (px_q != PX_W'(H_ACTIVE)) geom_d = 1'b1;
            if (half_q) begin
              push      = 1'b1;
              push_word = {20'h0, pack_q};
            end
            half_d = 1'b0;
            if (last_line) state_d = ST_DRAIN;
          end
          if (video_newframe && !(de_fall && last_line)) begin
            geom_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0 && !wr_valid_q) state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase

      // Dropped words still consume an address so later data lands in place.
      if (push) begin
        addr_d = addr_q + ADDR_W'(1);
        if (fifo_full) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      de_q    <= 1'b0;
      px_q    <= '0;
      ln_q    <= '0;
      half_q  <= 1'b0;
      pack_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      geom_q  <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= video_de;
      px_q    <= px_d;
      ln_q    <= ln_d;
      half_q  <= half_d;
      pack_q  <= pack_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      geom_q  <= geom_d;
      words_q <= words_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else if (abort) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q                 <= rd_ptr_q + PTR_W'(1);
        wr_valid_q               <= 1'b1;
        {wr_addr_q, wr_data_q}   <= fifo_mem[rd_ptr_q];
      end else if (wr_ready) begin
        wr_valid_q <= 1'b0;
      end
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {addr_q, push_word};
  end

  assign busy          = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign err_overflow  = ovf_q;
  assign err_geom      = geom_q;
  assign words_written = words_q;
  assign wr_valid      = wr_valid_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture: random frames against an array-based model of the
// decimated, packed image, plus abort / reset / same-cycle corner sequences.
module tb_video_capture;

  localparam int H     = 32;
  localparam int V     = 12;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n, start, abort;
  logic [3:0]    video_r, video_g, video_b;
  logic          video_de, video_hsync, video_vsync, video_newframe;
  logic          busy, done, err_overflow, err_geom;
  logic [AW-1:0] words_written;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .video_r(video_r), .video_g(video_g), .video_b(video_b),
    .video_de(video_de), .video_hsync(video_hsync), .video_vsync(video_vsync),
    .video_newframe(video_newframe),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_geom(err_geom),
    .words_written(words_written),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rdy;        // 0: ready held low, N: ready high one cycle in N
    int short_y;    // line with odd length, -1 for none
    int short_len;
    int early;      // newframe after this line, -1 for full frame
    bit start_mid;  // extra start pulse inside the frame
    bit exp_geom;
    bit exp_ovf;
  } vec_t;

  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  int             rdy_period, rphase;
  int             done_cnt, t_word, t_valid;
  bit             seen_valid, hold_en, hold_pend;
  logic [AW-1:0]  hold_addr;
  logic [31:0]    hold_data;
  logic [11:0]    img [16][40];
  logic [31:0]    exp_q [$];
  logic [47:0]    got_q [$];
  vec_t           vecs [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_period <= 0) wr_ready = 1'b0;
    else begin
      rphase++;
      if (rphase >= rdy_period) rphase = 0;
      wr_ready = (rphase == 0);
    end
  endtask

  function automatic logic [68:0] outv();
    return {busy, done, err_overflow, err_geom, words_written, wr_valid, wr_addr, wr_data};
  endfunction

  // Expected capture: even pixels of even lines, paired low-first, odd leftover zero-padded.
  function automatic void build_exp(input int nl, input int sy, input int slen);
    logic [11:0] held;
    bit have;
    int len;
    exp_q.delete();
    held = '0;
    for (int y = 0; y < nl; y++) begin
      if (y % 2 == 0) begin
        len  = (y == sy) ? slen : H;
        have = 1'b0;
        for (int x = 0; x < len; x += 2) begin
          if (have) begin
            exp_q.push_back({4'h0, img[y][x], 4'h0, held});
            have = 1'b0;
          end else begin
            held = img[y][x];
            have = 1'b1;
          end
        end
        if (have) exp_q.push_back({20'h0, held});
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) hold_pend = 1'b0;
    else begin
      if (hold_en && hold_pend)
        check("wr_hold_stable", {wr_valid, wr_addr, wr_data}, {1'b1, hold_addr, hold_data});
      hold_pend = wr_valid && !wr_ready;
      hold_addr = wr_addr;
      hold_data = wr_data;
      if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
      if (done) done_cnt++;
      if (wr_valid && !seen_valid) begin
        seen_valid = 1'b1;
        t_valid    = cyc;
      end
    end
  end

  task automatic newframe_pulse();
    video_newframe = 1'b1; video_vsync = 1'b1;
    tick();
    video_newframe = 1'b0; video_vsync = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int nl, len, bad, last;
    rdy_period = v.rdy; rphase = 0; hold_en = 1'b1;
    got_q.delete(); done_cnt = 0; seen_valid = 1'b0; t_word = 0; t_valid = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 40; x++) img[y][x] = 12'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    repeat (3) tick();
    newframe_pulse();
    repeat (2) tick();
    nl = (v.early >= 0) ? v.early + 1 : V;
    for (int y = 0; y < nl; y++) begin
      len = (y == v.short_y) ? v.short_len : H;
      for (int x = 0; x < len; x++) begin
        video_de = 1'b1; video_hsync = 1'b0;
        {video_r, video_g, video_b} = img[y][x];
        start = v.start_mid && (y == 2) && (x == 5);
        if (y == 0 && x == 2) t_word = cyc;
        tick();
      end
      start = 1'b0; video_de = 1'b0; video_hsync = 1'b1;
      {video_r, video_g, video_b} = 12'h0;
      repeat ($urandom_range(6, 3)) tick();
    end
    if (v.early >= 0) newframe_pulse();
    build_exp(nl, v.short_y, v.short_len);
    for (int i = 0; i < 3000 && busy; i++) tick();
    check({tag, "_drain_bound"}, busy, 0);
    repeat (3) tick();

    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_err_geom"}, err_geom, v.exp_geom);
    check({tag, "_err_overflow"}, err_overflow, v.exp_ovf);
    check({tag, "_latency"}, t_valid - t_word, 2);
    check({tag, "_ww_vs_handshakes"}, words_written, got_q.size());
    if (v.exp_ovf) check({tag, "_ww_below_total"}, words_written < exp_q.size(), 1);
    else           check({tag, "_ww_total"}, words_written, exp_q.size());
    bad = 0; last = -1;
    foreach (got_q[i]) begin
      if (int'(got_q[i][47:32]) >= exp_q.size() || int'(got_q[i][47:32]) <= last) bad++;
      else if (got_q[i][31:0] !== exp_q[got_q[i][47:32]]) bad++;
      last = int'(got_q[i][47:32]);
    end
    check({tag, "_bad_words"}, bad, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b1; abort = 1'b0;
    {video_r, video_g, video_b} = 12'h0;
    video_de = 1'b0; video_hsync = 1'b1; video_vsync = 1'b0; video_newframe = 1'b0;
    wr_ready = 1'b0; rdy_period = 1; rphase = 0; hold_en = 1'b1;
    done_cnt = 0; seen_valid = 1'b0;

    vecs[0] = '{1, -1,  0, -1, 1'b1, 1'b0, 1'b0};  // nominal, start ignored mid-frame
    vecs[1] = '{1,  4, 30, -1, 1'b0, 1'b1, 1'b0};  // short even line, partial word
    vecs[2] = '{1,  3, 20, -1, 1'b0, 1'b1, 1'b0};  // short odd line, data unaffected
    vecs[3] = '{1,  6, 36, -1, 1'b0, 1'b1, 1'b0};  // long even line
    vecs[4] = '{1,  2, 31, -1, 1'b0, 1'b1, 1'b0};  // one-short even line
    vecs[5] = '{1, -1,  0,  5, 1'b0, 1'b1, 1'b0};  // early newframe after line 5
    vecs[6] = '{16, -1, 0, -1, 1'b0, 1'b0, 1'b1};  // heavy backpressure
    vecs[7] = '{1, -1,  0, -1, 1'b0, 1'b0, 1'b0};  // clean run clears sticky errors

    repeat (3) tick();
    check("reset_state", outv(), '0);
    start = 1'b0; reset_n = 1'b1;
    repeat (2) tick();
    check("idle_after_reset", busy, 0);

    // Abort mid-line while a write is held by wr_ready=0.
    rdy_period = 0; hold_en = 1'b0; done_cnt = 0;
    start = 1'b1; tick(); start = 1'b0; tick();
    newframe_pulse(); tick();
    for (int x = 0; x < 30; x++) begin
      video_de = 1'b1; {video_r, video_g, video_b} = 12'(x);
      tick();
    end
    check("abort_pre_valid", wr_valid, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    video_de = 1'b0; {video_r, video_g, video_b} = 12'h0;
    check("abort_idle", {wr_valid, busy, done}, 3'b000);
    check("abort_hold_ovf", err_overflow, 1);
    check("abort_hold_words", words_written, 0);
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);

    // start and abort together in IDLE: abort wins, nothing is cleared.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);
    check("start_abort_hold_ovf", err_overflow, 1);
    tick();

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset in the middle of a capture.
    rdy_period = 1; hold_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    newframe_pulse(); tick();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < ((y == 2) ? 10 : H); x++) begin
        video_de = 1'b1; {video_r, video_g, video_b} = 12'($urandom);
        tick();
      end
      if (y < 2) begin
        video_de = 1'b0;
        repeat (4) tick();
      end
    end
    check("pre_reset_words_nonzero", words_written != '0, 1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", outv(), '0);
    video_de = 1'b0; start = 1'b1;
    repeat (2) tick();
    start = 1'b0; reset_n = 1'b1;
    tick();
    check("start_ignored_in_reset", busy, 0);
    run_vec("post_reset", vecs[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
